mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

MEM-stage data-memory access controller. Takes the load/store request held in the EX/MEM pipeline register and runs it on a req/ack data-memory bus. While the access is in flight it stalls the pipeline. It also generates byte enables, aligns and extends load data, and flags misaligned accesses.

## Interface

Parameters
- TIMEOUT_CYCLES, 255: max cycles spent in REQ before abort (only used with MEM_TIMEOUT_EN); range 1..65535.

Ports
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- memread_MEM  in  1  load pending in MEM stage.
- memwrite_MEM  in  1  store pending in MEM stage.
- funct3_MEM  in  3  RV32I load/store funct3.
- addr_MEM  in  32  byte address (ALU result).
- wdata_MEM  in  32  store data (rs2).
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB.
- load_data  out  32  aligned, extended load result.
- load_valid  out  1  load_data valid this cycle.
- misalign_err  out  1  misaligned/illegal access, one-cycle pulse.
- timeout_err  out  1  access aborted by watchdog, one-cycle pulse.
- dmem_req  out  1  bus request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address: {addr_MEM[31:2],2'b00}.
- dmem_wdata  out  32  store data, replicated per size.
- dmem_be  out  4  byte enables, all 0 on reads.
- dmem_rdata  in  32  read data, sampled when dmem_ack=1.
- dmem_ack  in  1  completion, single-cycle pulse, only while dmem_req=1.

## Operation

- FSM states: IDLE, REQ, DONE. All state and outputs reset to 0 / IDLE.
- Access is pending when memread_MEM|memwrite_MEM. If both are set, treat it as a read; no write is issued.
- Size comes from funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- Misaligned cases:
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - funct3[1:0]=11
- IDLE:
  - Pending and aligned: stall=1 (combinational); go to REQ.
  - Pending and misaligned: misalign_err=1 this cycle, stall=0, no bus activity; stay in IDLE.
  - No pending access: all idle.
- REQ:
  - dmem_req=1 and stall=1.
  - dmem_we, dmem_addr, dmem_wdata and dmem_be are registered on the IDLE→REQ edge and held stable.
  - On dmem_ack: capture dmem_rdata; go to DONE.
- DONE:
  - stall=0; pipeline advances at the end of this cycle.
  - On a load, load_valid=1 and load_data holds the registered extracted value.
  - Always returns to IDLE; the still-asserted memread/memwrite does not reissue.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Write data: byte is {4{wdata[7:0]}}, half is {2{wdata[15:0]}}, word passes through.
- Load extract: select the byte/half by addr[1:0]. Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
- load_data is held between loads; it is zeroed on reset.
- Async reset mid-REQ: dmem_req and stall drop immediately and the FSM goes to IDLE. A later stray ack is ignored.
- An ack outside REQ is ignored.

## Timing

- Access latency: cycle 0 IDLE (stall=1), cycle 1 first REQ cycle. An ack in cycle k≥1 gives DONE in cycle k+1.
- Total stall is k+1 cycles; minimum 2 (ack in the first REQ cycle).
- load_valid and load_data are registered, valid in the DONE cycle only, for the MEM/WB register to sample at that edge.
- misalign_err is combinational in the IDLE cycle and adds no stall.
- Back-to-back accesses: the next access is seen in IDLE in the cycle after DONE, with no idle gap beyond that.

## Configuration

- MEM_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to REQ and increments on each REQ cycle without ack.
  - On reaching TIMEOUT_CYCLES it drops dmem_req and goes to DONE with load_data=0. timeout_err=1 in that DONE cycle and load_valid is asserted for a load.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- MEM_TIMEOUT_EN undefined: no counter. REQ waits indefinitely and timeout_err is tied 0.

## Test plan

- Reset asserted: all outputs 0, FSM IDLE; reset pulsed mid-REQ drops dmem_req in the same cycle.
- LW addr=0x104, ack on first REQ cycle, rdata=0xDEADBEEF: stall high 2 cycles; load_data=0xDEADBEEF, load_valid for 1 cycle; dmem_addr=0x104, be=0.
- LB addr=0x203, rdata=0x80112233: load_data=0xFFFFFF80. LBU: 0x00000080. LHU addr=0x202: 0x00008011.
- SB addr=0x301, wdata=0x000000A5, ack after 3 REQ cycles: dmem_be=0010, dmem_wdata=0xA5A5A5A5, dmem_we=1, stall 4 cycles.
- LW addr=0x102 and funct3=011: misalign_err pulse, dmem_req stays 0, stall 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack: dmem_req high 4 cycles, then DONE with timeout_err=1, load_data=0, pipeline released.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: runs one req/ack data-memory access per request and stalls the pipeline meanwhile.
// Optional watchdog abort of a stuck REQ is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_MEM,
  input  logic        memwrite_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] wdata_MEM,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic        pending, misaligned, start, abort;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] extract;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic        rd_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic [31:0] load_data_reg;
  logic        load_valid_reg;
  logic        timeout_reg;

  // Gating with reset keeps stall low for the whole time reset is held,
  // even if the MEM-stage request is still present.
  assign pending = (memread_MEM | memwrite_MEM) & ~reset;

  always_comb begin
    misaligned = 1'b0;
    case (funct3_MEM[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_MEM[0];
      2'b10:   misaligned = (addr_MEM[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign start        = (state_reg == S_IDLE) & pending & ~misaligned;
  assign misalign_err = (state_reg == S_IDLE) & pending & misaligned;
  assign stall        = start | (state_reg == S_REQ);
  assign dmem_req     = (state_reg == S_REQ);

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata_MEM;
    case (funct3_MEM[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr_MEM[1:0];
        wdata_calc = {4{wdata_MEM[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {addr_MEM[1], 1'b0};
        wdata_calc = {2{wdata_MEM[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_MEM;
      end
    endcase
  end

  // Extraction uses the offset/size latched at issue, not the live MEM inputs.
  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (off_reg)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    extract  = dmem_rdata;
    case (funct3_reg[1:0])
      2'b00:   extract = {{24{~funct3_reg[2] & byte_sel[7]}}, byte_sel};
      2'b01:   extract = {{16{~funct3_reg[2] & half_sel[15]}}, half_sel};
      default: extract = dmem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= 16'd0;
    end else if (start) begin
      cnt_reg <= 16'd0;
    end else if ((state_reg == S_REQ) && !dmem_ack) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  // Fires on the REQ cycle that would bring the count to the limit; an ack wins.
  assign abort = (state_reg == S_REQ) && !dmem_ack &&
                 (({1'b0, cnt_reg} + 17'd1) == 17'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
  assign abort = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  state_next = start ? S_REQ : S_IDLE;
      S_REQ:   state_next = (dmem_ack || abort) ? S_DONE : S_REQ;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg         <= 1'b0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      be_reg         <= 4'd0;
      rd_reg         <= 1'b0;
      funct3_reg     <= 3'd0;
      off_reg        <= 2'd0;
      load_data_reg  <= 32'd0;
      load_valid_reg <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      load_valid_reg <= 1'b0;
      timeout_reg    <= 1'b0;
      if (start) begin
        // A simultaneous read+write is issued as a plain read.
        we_reg     <= memwrite_MEM & ~memread_MEM;
        addr_reg   <= {addr_MEM[31:2], 2'b00};
        wdata_reg  <= wdata_calc;
        be_reg     <= memread_MEM ? 4'b0000 : be_calc;
        rd_reg     <= memread_MEM;
        funct3_reg <= funct3_MEM;
        off_reg    <= addr_MEM[1:0];
      end
      if (state_reg == S_REQ) begin
        if (dmem_ack) begin
          load_valid_reg <= rd_reg;
          if (rd_reg) begin
            load_data_reg <= extract;
          end
        end else if (abort) begin
          load_valid_reg <= rd_reg;
          timeout_reg    <= 1'b1;
          if (rd_reg) begin
            load_data_reg <= 32'd0;
          end
        end
      end
    end
  end

  assign dmem_we     = we_reg;
  assign dmem_addr   = addr_reg;
  assign dmem_wdata  = wdata_reg;
  assign dmem_be     = be_reg;
  assign load_data   = load_data_reg;
  assign load_valid  = load_valid_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed accesses with a load-data scoreboard; timeout scenarios need MEM_TIMEOUT_EN.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread_MEM = 1'b0;
  logic        memwrite_MEM = 1'b0;
  logic [2:0]  funct3_MEM = 3'd0;
  logic [31:0] addr_MEM = 32'd0;
  logic [31:0] wdata_MEM = 32'd0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign_err;
  logic        timeout_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'd0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM),
    .funct3_MEM(funct3_MEM), .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misalign_err(misalign_err), .timeout_err(timeout_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  // Scoreboard: every load_valid pulse must match the oldest expected load result.
  always @(negedge clk) begin
    if (!reset && load_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: load_valid with load_data=%h, nothing expected", load_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (load_data !== e) begin
          errors++;
          $display("FAIL sb_load_data: got %h expected %h", load_data, e);
        end else begin
          $display("sb load_data=%h ok", load_data);
        end
      end
    end
  end

  // Drives one access from its IDLE cycle through DONE; ack_after=0 means never ack.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ack_after,
                            output int stall_n, output int req_n,
                            output logic we_c, output logic [31:0] addr_c,
                            output logic [31:0] wdata_c, output logic [3:0] be_c,
                            output logic lv, output logic [31:0] ld, output logic te,
                            output logic merr0, output logic req0, output logic ok);
    int cyc;
    logic done;
    @(negedge clk);
    memread_MEM = rd; memwrite_MEM = wr; funct3_MEM = f3;
    addr_MEM = addr; wdata_MEM = wd; dmem_ack = 1'b0;
    #1;
    stall_n = 0; req_n = 0; cyc = 0; done = 1'b0; ok = 1'b0;
    we_c = 1'b0; addr_c = 32'd0; wdata_c = 32'd0; be_c = 4'd0;
    lv = 1'b0; ld = 32'd0; te = 1'b0;
    merr0 = misalign_err; req0 = dmem_req;
    while (!done && cyc < 40) begin
      if (stall) begin
        stall_n++;
      end else begin
        done = 1'b1; ok = 1'b1;
        lv = load_valid; ld = load_data; te = timeout_err;
      end
      if (dmem_req) begin
        req_n++;
        if (req_n == 1) begin
          we_c = dmem_we; addr_c = dmem_addr; wdata_c = dmem_wdata; be_c = dmem_be;
        end
        dmem_ack   = (req_n == ack_after);
        dmem_rdata = (req_n == ack_after) ? rdata : ~rdata;
      end else begin
        dmem_ack = 1'b0;
      end
      if (!done) begin
        @(negedge clk); #1; cyc++;
      end
    end
    memread_MEM = 1'b0; memwrite_MEM = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({stall, dmem_req, load_valid, misalign_err, timeout_err, dmem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {stall, dmem_req, load_valid, misalign_err, timeout_err, dmem_we});
    end
    checks++;
    if ({load_data, dmem_addr, dmem_wdata, dmem_be} !== 100'd0) begin
      errors++;
      $display("FAIL reset_data: load_data=%h addr=%h wdata=%h be=%b expected zeros", load_data, dmem_addr, dmem_wdata, dmem_be);
    end
    reset = 1'b0;
    $display("reset: state checked");
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_data,
                           input string name);
    int sn, rn;
    logic we_c, lv, te, m0, r0, ok;
    logic [31:0] a_c, w_c, ld;
    logic [3:0] b_c;
    exp_q.push_back(exp_data);
    last_load = exp_data;
    run_access(1'b1, 1'b0, f3, addr, 32'h0, rdata, 1, sn, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok);
    checks++;
    if (!ok || sn !== 2 || rn !== 1) begin
      errors++;
      $display("FAIL %s_timing: ok=%0d stall=%0d req=%0d expected stall=2 req=1", name, ok, sn, rn);
    end
    checks++;
    if (a_c !== {addr[31:2], 2'b00} || b_c !== 4'b0000 || we_c !== 1'b0) begin
      errors++;
      $display("FAIL %s_bus: addr=%h be=%b we=%b expected addr=%h be=0000 we=0", name, a_c, b_c, we_c, {addr[31:2], 2'b00});
    end
    checks++;
    if (lv !== 1'b1 || ld !== exp_data || te !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: lv=%b data=%h te=%b expected lv=1 data=%h te=0", name, lv, ld, te, exp_data);
    end
    @(negedge clk); #1;
    checks++;
    if (load_valid !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: load_valid=%b dmem_req=%b expected 0 0", name, load_valid, dmem_req);
    end
    $display("%s addr=%h data=%h stall=%0d", name, addr, ld, sn);
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_after, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input string name);
    int sn, rn;
    logic we_c, lv, te, m0, r0, ok;
    logic [31:0] a_c, w_c, ld;
    logic [3:0] b_c;
    run_access(1'b0, 1'b1, f3, addr, wd, 32'h0, ack_after, sn, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok);
    checks++;
    if (!ok || sn !== ack_after + 1 || rn !== ack_after) begin
      errors++;
      $display("FAIL %s_timing: ok=%0d stall=%0d req=%0d expected stall=%0d req=%0d", name, ok, sn, rn, ack_after + 1, ack_after);
    end
    checks++;
    if (we_c !== 1'b1 || b_c !== exp_be || w_c !== exp_wd || a_c !== {addr[31:2], 2'b00}) begin
      errors++;
      $display("FAIL %s_bus: we=%b be=%b wdata=%h addr=%h expected we=1 be=%b wdata=%h addr=%h",
               name, we_c, b_c, w_c, a_c, exp_be, exp_wd, {addr[31:2], 2'b00});
    end
    checks++;
    if (lv !== 1'b0 || ld !== last_load) begin
      errors++;
      $display("FAIL %s_noload: lv=%b load_data=%h expected lv=0 held %h", name, lv, ld, last_load);
    end
    $display("%s addr=%h be=%b wdata=%h stall=%0d", name, addr, b_c, w_c, sn);
  endtask

  task automatic test_misalign(input logic [2:0] f3, input logic [31:0] addr, input string name);
    int sn, rn;
    logic we_c, lv, te, m0, r0, ok;
    logic [31:0] a_c, w_c, ld;
    logic [3:0] b_c;
    run_access(1'b1, 1'b0, f3, addr, 32'h0, 32'h0, 1, sn, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok);
    checks++;
    if (m0 !== 1'b1 || r0 !== 1'b0 || sn !== 0) begin
      errors++;
      $display("FAIL %s: misalign_err=%b dmem_req=%b stall=%0d expected 1 0 0", name, m0, r0, sn);
    end
    @(negedge clk); #1;
    checks++;
    if (dmem_req !== 1'b0 || misalign_err !== 1'b0 || load_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: dmem_req=%b misalign_err=%b load_valid=%b expected 0 0 0", name, dmem_req, misalign_err, load_valid);
    end
    $display("%s addr=%h funct3=%b misalign_err=%b", name, addr, f3, m0);
  endtask

  task automatic test_read_write_both;
    int sn, rn;
    logic we_c, lv, te, m0, r0, ok;
    logic [31:0] a_c, w_c, ld;
    logic [3:0] b_c;
    exp_q.push_back(32'h0000_5A5A);
    last_load = 32'h0000_5A5A;
    run_access(1'b1, 1'b1, 3'b101, 32'h0000_0410, 32'hFFFF_FFFF, 32'h1111_5A5A, 2,
               sn, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok);
    checks++;
    if (we_c !== 1'b0 || b_c !== 4'b0000 || lv !== 1'b1 || sn !== 3) begin
      errors++;
      $display("FAIL rw_both: we=%b be=%b lv=%b stall=%0d expected 0 0000 1 3", we_c, b_c, lv, sn);
    end
    $display("rw_both data=%h we=%b", ld, we_c);
  endtask

  task automatic test_back_to_back;
    int sn1, sn2, sn3, rn;
    logic we_c, lv, te, m0, r0, ok1, ok2, ok3;
    logic [31:0] a_c, w_c, ld;
    logic [3:0] b_c;
    exp_q.push_back(32'hCAFE_0001);
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'hCAFE_0001, 1, sn1, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok1);
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0504, 32'h7777_8888, 32'h0, 2, sn2, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok2);
    checks++;
    if (w_c !== 32'h7777_8888 || b_c !== 4'b1111 || a_c !== 32'h0000_0504) begin
      errors++;
      $display("FAIL b2b_sw_bus: wdata=%h be=%b addr=%h expected 77778888 1111 00000504", w_c, b_c, a_c);
    end
    exp_q.push_back(32'hFFFF_FF9C);
    last_load = 32'hFFFF_FF9C;
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0509, 32'h0, 32'h0000_9C00, 1, sn3, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok3);
    checks++;
    if (!ok1 || !ok2 || !ok3 || sn1 !== 2 || sn2 !== 3 || sn3 !== 2) begin
      errors++;
      $display("FAIL b2b_timing: stalls=%0d/%0d/%0d expected 2/3/2", sn1, sn2, sn3);
    end
    $display("b2b stalls=%0d/%0d/%0d", sn1, sn2, sn3);
  endtask

  task automatic test_reset_mid_req;
    int cyc;
    @(negedge clk);
    memread_MEM = 1'b1; funct3_MEM = 3'b010; addr_MEM = 32'h0000_0600; dmem_ack = 1'b0;
    cyc = 0;
    while (dmem_req !== 1'b1 && cyc < 10) begin
      @(negedge clk); cyc++;
    end
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: dmem_req=%b stall=%b expected 1 1", dmem_req, stall);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: dmem_req=%b stall=%b expected 0 0", dmem_req, stall);
    end
    memread_MEM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (load_valid !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_stray_ack: load_valid=%b dmem_req=%b stall=%b load_data=%h expected 0 0 0 0",
               load_valid, dmem_req, stall, load_data);
    end
    last_load = 32'd0;
    $display("reset_mid_req: dmem_req dropped, stray ack ignored");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int sn, rn;
    logic we_c, lv, te, m0, r0, ok;
    logic [31:0] a_c, w_c, ld;
    logic [3:0] b_c;
    exp_q.push_back(32'h0);
    last_load = 32'h0;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 32'h1234_5678, 0, sn, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok);
    checks++;
    if (!ok || rn !== 4 || sn !== 5 || te !== 1'b1 || lv !== 1'b1 || ld !== 32'd0) begin
      errors++;
      $display("FAIL timeout_abort: ok=%0d req=%0d stall=%0d te=%b lv=%b data=%h expected 1 4 5 1 1 0", ok, rn, sn, te, lv, ld);
    end
    exp_q.push_back(32'h1234_5678);
    last_load = 32'h1234_5678;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0704, 32'h0, 32'h1234_5678, 4, sn, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok);
    checks++;
    if (!ok || rn !== 4 || te !== 1'b0 || ld !== 32'h1234_5678) begin
      errors++;
      $display("FAIL timeout_ack_wins: req=%0d te=%b data=%h expected 4 0 12345678", rn, te, ld);
    end
    $display("timeout scenarios done");
  endtask
`else
  task automatic test_no_timeout;
    int sn, rn;
    logic we_c, lv, te, m0, r0, ok;
    logic [31:0] a_c, w_c, ld;
    logic [3:0] b_c;
    exp_q.push_back(32'h0BAD_F00D);
    last_load = 32'h0BAD_F00D;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 32'h0BAD_F00D, 20, sn, rn, we_c, a_c, w_c, b_c, lv, ld, te, m0, r0, ok);
    checks++;
    if (!ok || rn !== 20 || sn !== 21 || te !== 1'b0 || ld !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL long_wait: ok=%0d req=%0d stall=%0d te=%b data=%h expected 1 20 21 0 0badf00d", ok, rn, sn, te, ld);
    end
    $display("long wait req=%0d stall=%0d", rn, sn);
  endtask
`endif

  initial begin
    test_reset();
    test_load(3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");
    test_load(3'b000, 32'h0000_0203, 32'h8011_2233, 32'hFFFF_FF80, "lb");
    test_load(3'b100, 32'h0000_0203, 32'h8011_2233, 32'h0000_0080, "lbu");
    test_load(3'b101, 32'h0000_0202, 32'h8011_2233, 32'h0000_8011, "lhu");
    test_load(3'b001, 32'h0000_0200, 32'h1234_F00D, 32'hFFFF_F00D, "lh");
    test_store(3'b000, 32'h0000_0301, 32'h0000_00A5, 3, 4'b0010, 32'hA5A5_A5A5, "sb");
    test_store(3'b001, 32'h0000_0302, 32'h0000_BEEF, 2, 4'b1100, 32'hBEEF_BEEF, "sh");
    test_store(3'b010, 32'h0000_0308, 32'h1234_5678, 1, 4'b1111, 32'h1234_5678, "sw");
    test_misalign(3'b010, 32'h0000_0102, "mis_lw");
    test_misalign(3'b001, 32'h0000_0101, "mis_lh");
    test_misalign(3'b011, 32'h0000_0100, "mis_f3");
    test_read_write_both();
    test_back_to_back();
    test_reset_mid_req();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected loads never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
